// File: rtl/digit_serial_adder_pkg.sv
// Shared types and cell-cost constants for the digit-serial adder.
// Included by every digit_serial_adder source file.
package digit_serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Static transistor cost of each library cell used by this block.
  localparam int FA1_COST    = 26;
  localparam int FD2_COST    = 27;
  localparam int MUX21H_COST = 12;
  localparam int CTRL_COST   = 40;

  localparam int NUMBER_W = 51;

  // Cost of a bank of FD2 flip-flops of the given total width.
  function automatic int fd2_bank_cost(input int bits);
    return FD2_COST * bits;
  endfunction

endpackage : digit_serial_adder_pkg

// File: rtl/digit_serial_adder_digit_adder.sv
// DW-bit ripple of FA1 cells with carry in/out; reports its own cell cost.
module digit_adder
  import digit_serial_adder_pkg::*;
#(
  parameter int DW = 4
) (
  input  logic [DW-1:0]       i_a,
  input  logic [DW-1:0]       i_b,
  input  logic                i_ci,
  output logic [DW-1:0]       o_s,
  output logic                o_co,
  output logic [NUMBER_W-1:0] number
);

  logic [DW:0] w_c;

  assign w_c[0] = i_ci;

  for (genvar g = 0; g < DW; g++) begin : g_fa1
    assign o_s[g]     = i_a[g] ^ i_b[g] ^ w_c[g];
    assign w_c[g + 1] = (i_a[g] & i_b[g]) | (w_c[g] & (i_a[g] ^ i_b[g]));
  end

  assign o_co   = w_c[DW];
  assign number = NUMBER_W'(FA1_COST * DW);

endmodule : digit_adder

// File: rtl/digit_serial_adder.sv
// Multi-cycle adder: BW-bit operands summed DW bits per clock over N = BW/DW edges.
// Define DIGIT_SERIAL_ACC_EN for accumulate mode (o_s feeds back as operand A, i_clr port).
module digit_serial_adder
  import digit_serial_adder_pkg::*;
#(
  parameter int BW = 16,
  parameter int DW = 4
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                i_start,
  input  logic [BW-1:0]       i_a,
  input  logic [BW-1:0]       i_b,
`ifdef DIGIT_SERIAL_ACC_EN
  input  logic                i_clr,
`endif
  output logic [BW-1:0]       o_s,
  output logic                o_c,
  output logic                o_busy,
  output logic                o_done,
  output logic [NUMBER_W-1:0] number
);

  localparam int N  = BW / DW;
  localparam int CW = $clog2(N);

  // a_sh, b_sh, sum (3*BW), carry, cnt and the 2-bit state.
  localparam int REG_BITS = 3 * BW + 1 + CW + 2;
`ifdef DIGIT_SERIAL_ACC_EN
  localparam int ACC_COST = MUX21H_COST * BW;
`else
  localparam int ACC_COST = 0;
`endif

  state_t          r_state;
  logic [BW-1:0]   r_a_sh;
  logic [BW-1:0]   r_b_sh;
  logic [BW-1:0]   r_sum;
  logic            r_carry;
  logic [CW-1:0]   r_cnt;
`ifdef DIGIT_SERIAL_ACC_EN
  logic            r_clr_pend;
`endif

  logic [DW-1:0]       w_d;
  logic                w_cy;
  logic [BW-1:0]       w_sum_next;
  logic                w_accept;
  logic                w_last;
  logic [BW-1:0]       w_a_load;
  logic [NUMBER_W-1:0] w_da_number;

  digit_adder #(
    .DW(DW)
  ) u_digit_adder (
    .i_a    (r_a_sh[DW-1:0]),
    .i_b    (r_b_sh[DW-1:0]),
    .i_ci   (r_carry),
    .o_s    (w_d),
    .o_co   (w_cy),
    .number (w_da_number)
  );

  assign w_sum_next = {w_d, r_sum[BW-1:DW]};
  assign w_accept   = i_start && (r_state != ST_RUN);
  assign w_last     = (r_cnt == CW'(N - 1));

`ifdef DIGIT_SERIAL_ACC_EN
  // The running total re-enters as operand A; i_a is unused in this mode.
  assign w_a_load = i_clr ? '0 : o_s;
`else
  assign w_a_load = i_a;
`endif

  // NOTE: every state register, including the datapath shifters, gets a
  // reset value so an abort mid-RUN leaves no stale partial sum behind.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state    <= ST_IDLE;
      r_a_sh     <= '0;
      r_b_sh     <= '0;
      r_sum      <= '0;
      r_carry    <= 1'b0;
      r_cnt      <= '0;
`ifdef DIGIT_SERIAL_ACC_EN
      r_clr_pend <= 1'b0;
`endif
      o_s        <= '0;
      o_c        <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, exactly like the FD2 cells they map to.
      case (r_state)
        ST_RUN: begin
          r_a_sh  <= r_a_sh >> DW;
          r_b_sh  <= r_b_sh >> DW;
          r_sum   <= w_sum_next;
          r_carry <= w_cy;
          r_cnt   <= r_cnt + CW'(1);
          if (w_last) begin
            o_s <= w_sum_next;
`ifdef DIGIT_SERIAL_ACC_EN
            o_c <= w_cy | (o_c & ~r_clr_pend);
`else
            o_c <= w_cy;
`endif
            r_state <= ST_DONE;
            o_busy  <= 1'b0;
            o_done  <= 1'b1;
          end else begin
            o_done  <= 1'b0;
          end
        end

        default: begin
          // IDLE and DONE both accept a start; DONE lasts one cycle only.
          o_done <= 1'b0;
          if (w_accept) begin
            r_a_sh  <= w_a_load;
            r_b_sh  <= i_b;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
`ifdef DIGIT_SERIAL_ACC_EN
            r_clr_pend <= i_clr;
`endif
            r_state <= ST_RUN;
            o_busy  <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
            o_busy  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign number = w_da_number
                + NUMBER_W'(fd2_bank_cost(REG_BITS) + CTRL_COST + ACC_COST);

endmodule : digit_serial_adder

// File: tb/tb_digit_serial_adder.sv
// Self-checking bench for digit_serial_adder (BW=16, DW=4) against a cycle-count model.
// Compile with DIGIT_SERIAL_ACC_EN defined to exercise accumulate mode.
module tb_digit_serial_adder;

  localparam int BW = 16;
  localparam int DW = 4;
  localparam int N  = BW / DW;
`ifdef DIGIT_SERIAL_ACC_EN
  localparam logic [63:0] EXP_NUMBER = 64'd1767;
`else
  localparam logic [63:0] EXP_NUMBER = 64'd1575;
`endif

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          i_start = 1'b0;
  logic [BW-1:0] i_a = '0;
  logic [BW-1:0] i_b = '0;
  logic          i_clr = 1'b0;
  logic [BW-1:0] o_s;
  logic          o_c;
  logic          o_busy;
  logic          o_done;
  logic [50:0]   number;

  int n_vec  = 0;
  int n_fail = 0;
  logic chk_en = 1'b0;

  always #5 CLK = ~CLK;

  digit_serial_adder #(
    .BW(BW),
    .DW(DW)
  ) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .i_start (i_start),
    .i_a     (i_a),
    .i_b     (i_b),
`ifdef DIGIT_SERIAL_ACC_EN
    .i_clr   (i_clr),
`endif
    .o_s     (o_s),
    .o_c     (o_c),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .number  (number)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an accepted add produces its full-width sum exactly N
  // edges later; nothing else matters to the outputs.
  int            m_rem;
  logic [BW:0]   m_pend;
  logic [BW-1:0] m_s;
  logic          m_c;
  logic          m_done;
  logic          m_clr_pend;

  always @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      m_rem      <= 0;
      m_pend     <= '0;
      m_s        <= '0;
      m_c        <= 1'b0;
      m_done     <= 1'b0;
      m_clr_pend <= 1'b0;
    end else if (m_rem > 0) begin
      m_rem <= m_rem - 1;
      if (m_rem == 1) begin
        m_s    <= m_pend[BW-1:0];
`ifdef DIGIT_SERIAL_ACC_EN
        m_c    <= m_pend[BW] | (m_c & ~m_clr_pend);
`else
        m_c    <= m_pend[BW];
`endif
        m_done <= 1'b1;
      end else begin
        m_done <= 1'b0;
      end
    end else begin
      m_done <= 1'b0;
      if (i_start) begin
`ifdef DIGIT_SERIAL_ACC_EN
        m_pend <= (i_clr ? {(BW+1){1'b0}} : {1'b0, m_s}) + {1'b0, i_b};
`else
        m_pend <= {1'b0, i_a} + {1'b0, i_b};
`endif
        m_clr_pend <= i_clr;
        m_rem      <= N;
      end
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      check("o_s",    64'(o_s),    64'(m_s));
      check("o_c",    64'(o_c),    64'(m_c));
      check("o_busy", 64'(o_busy), 64'(m_rem > 0));
      check("o_done", 64'(o_done), 64'(m_done));
    end
  end

  // Presents a one-cycle start; returns just after the accepting edge.
  task automatic start_op(input logic [BW-1:0] a, input logic [BW-1:0] b, input logic clr);
    @(posedge CLK); #1;
    i_start = 1'b1; i_a = a; i_b = b; i_clr = clr;
    @(posedge CLK); #1;
    i_start = 1'b0;
  endtask

  // Counts busy cycles until o_done is seen; bounded.
  task automatic wait_done(output int busy_cycles);
    int guard;
    busy_cycles = 0;
    guard = 0;
    @(negedge CLK);
    while (!o_done && guard < 40) begin
      if (o_busy) busy_cycles++;
      guard++;
      @(negedge CLK);
    end
    if (!o_done) check("done_timeout", 64'(o_done), 64'd1);
  endtask

  task automatic expect_result(input string name, input logic [BW-1:0] s, input logic c);
    check({name, "_s"}, 64'(o_s), 64'(s));
    check({name, "_c"}, 64'(o_c), 64'(c));
  endtask

  initial begin
    int cyc;
    #2 RESET = 1'b0;
    #1 chk_en = 1'b1;
    check("number_in_reset", 64'(number), EXP_NUMBER);
    check("o_s_reset", 64'(o_s), 64'd0);
    check("o_done_reset", 64'(o_done), 64'd0);
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b1;

`ifndef DIGIT_SERIAL_ACC_EN
    start_op(16'h1234, 16'h4321, 1'b0);
    wait_done(cyc);
    check("latency_cycles", 64'(cyc), 64'd4);
    expect_result("add_5555", 16'h5555, 1'b0);

    start_op(16'hFFFF, 16'h0001, 1'b0);
    wait_done(cyc);
    expect_result("carry_ripple", 16'h0000, 1'b1);

    // Back-to-back: start held through DONE with new operands.
    @(posedge CLK); #1;
    i_start = 1'b1; i_a = 16'h00FF; i_b = 16'h0001;
    @(posedge CLK); #1;
    i_a = 16'h8000; i_b = 16'h8000;
    wait_done(cyc);
    expect_result("b2b_first", 16'h0100, 1'b0);
    @(posedge CLK); #1;
    i_start = 1'b0;
    wait_done(cyc);
    check("b2b_no_bubble", 64'(cyc), 64'd4);
    expect_result("b2b_second", 16'h0000, 1'b1);

    // Start pulsed during RUN is ignored.
    start_op(16'h1111, 16'h2222, 1'b0);
    #1 i_start = 1'b1; i_a = 16'h7777; i_b = 16'h7777;
    @(posedge CLK); #1 i_start = 1'b0;
    wait_done(cyc);
    expect_result("ignore_start", 16'h3333, 1'b0);
    repeat (8) @(negedge CLK);

    // Abort in the second RUN cycle.
    start_op(16'h0F0F, 16'h0101, 1'b0);
    @(posedge CLK); #1 RESET = 1'b0;
    #1;
    expect_result("abort", 16'h0000, 1'b0);
    check("abort_busy", 64'(o_busy), 64'd0);
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b1;
    repeat (6) @(negedge CLK);
    check("abort_idle_busy", 64'(o_busy), 64'd0);
    start_op(16'h0F0F, 16'h0101, 1'b0);
    wait_done(cyc);
    expect_result("after_abort", 16'h1010, 1'b0);
`else
    start_op(16'hAAAA, 16'h0100, 1'b1);
    wait_done(cyc);
    check("acc_latency", 64'(cyc), 64'd4);
    expect_result("acc_clr", 16'h0100, 1'b0);
    start_op(16'hAAAA, 16'h0100, 1'b0);
    wait_done(cyc);
    expect_result("acc_2", 16'h0200, 1'b0);
    start_op(16'h5555, 16'h0100, 1'b0);
    wait_done(cyc);
    expect_result("acc_3", 16'h0300, 1'b0);
    start_op(16'h0000, 16'hFF00, 1'b0);
    wait_done(cyc);
    expect_result("acc_wrap", 16'h0200, 1'b1);
    start_op(16'h0000, 16'h0001, 1'b0);
    wait_done(cyc);
    expect_result("acc_sticky", 16'h0201, 1'b1);
    start_op(16'h0000, 16'h0005, 1'b1);
    wait_done(cyc);
    expect_result("acc_clr2", 16'h0005, 1'b0);
`endif

    // Randomised traffic: starts at any time, occasional resets.
    for (int i = 0; i < 1500; i++) begin
      @(posedge CLK); #1;
      i_start = ($urandom_range(0, 2) == 0);
      i_a     = BW'($urandom);
      i_b     = BW'($urandom);
      i_clr   = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 149) == 0) begin
        RESET = 1'b0;
        @(posedge CLK); #1;
        RESET = 1'b1;
      end
    end
    i_start = 1'b0;
    repeat (N + 3) @(posedge CLK);
    @(negedge CLK);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule : tb_digit_serial_adder
